// File: rtl/gen_fifo_defines_pkg.sv
// Shared sizing defaults and helpers for the generator sample FIFO.
// DATA_WIDTH macro defaults to 16 when not supplied by the build.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package gen_fifo_defines_pkg;

   localparam int unsigned FIFO_DATA_WIDTH = `DATA_WIDTH;
   localparam int unsigned FIFO_DEPTH      = 16;
   localparam int unsigned FIFO_AF_LEVEL   = FIFO_DEPTH - 2;

   // Pointer width: address bits plus one wrap bit (also the occupancy width).
   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/gen_fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one registered
// read port. Storage is never reset; the read register has a synchronous clear.
module gen_fifo_mem
   import gen_fifo_defines_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int unsigned DEPTH      = FIFO_DEPTH,
   parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en_i,
   input  logic [ADDR_W-1:0]     wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_W-1:0]     rd_addr_i,
   input  logic                  rd_clr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [DATA_WIDTH-1:0] rd_data_d;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Read register holds its value when no read is requested.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_clr_i) begin
         rd_data_d = '0;
      end else if (rd_en_i) begin
         rd_data_d = mem_q[rd_addr_i];
      end
   end

   always_ff @(posedge clk) begin
      rd_data_q <= rd_data_d;
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/gen_sync_fifo.sv
// Synchronous sample FIFO behind funct_generator with full/empty/almost-full status.
// Optional sticky overflow/underflow outputs are enabled by GEN_FIFO_ERR_FLAGS_EN.
module gen_sync_fifo
   import gen_fifo_defines_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int unsigned DEPTH      = FIFO_DEPTH,
   parameter int unsigned AF_LEVEL   = DEPTH - 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en_i,
   input  logic [DATA_WIDTH-1:0]     wr_data_i,
   input  logic                      rd_en_i,
   output logic [DATA_WIDTH-1:0]     rd_data_o,
   output logic                      rd_valid_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic                      almost_full_o,
   output logic [ptr_w(DEPTH)-1:0]   count_o
`ifdef GEN_FIFO_ERR_FLAGS_EN
   ,
   output logic                      overflow_o,
   output logic                      underflow_o
`endif
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned PTR_W  = ptr_w(DEPTH);
   localparam int unsigned CNT_W  = PTR_W;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             af_q, af_d;
   logic             rd_valid_q, rd_valid_d;
   logic             wr_acc;
   logic             rd_acc;

   // Accepts use pre-edge flags: a full FIFO drops writes, an empty one ignores reads.
   always_comb begin
      wr_acc     = wr_en_i && !full_q;
      rd_acc     = rd_en_i && !empty_q;
      wr_ptr_d   = wr_ptr_q + PTR_W'(wr_acc);
      rd_ptr_d   = rd_ptr_q + PTR_W'(rd_acc);
      count_d    = count_q;
      if (wr_acc && !rd_acc) begin
         count_d = count_q + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - CNT_W'(1);
      end
      full_d     = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                   (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
      empty_d    = (wr_ptr_d == rd_ptr_d);
      af_d       = (count_d >= CNT_W'(AF_LEVEL));
      rd_valid_d = rd_acc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         af_q       <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         af_q       <= af_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   gen_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_mem (
      .clk       (clk),
      .wr_en_i   (wr_acc),
      .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
      .wr_data_i (wr_data_i),
      .rd_en_i   (rd_acc),
      .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
      .rd_clr_i  (rst),
      .rd_data_o (rd_data_o)
   );

   assign rd_valid_o    = rd_valid_q;
   assign full_o        = full_q;
   assign empty_o       = empty_q;
   assign almost_full_o = af_q;
   assign count_o       = count_q;

`ifdef GEN_FIFO_ERR_FLAGS_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // Sticky until reset; set on any request the current flags refuse.
   always_comb begin
      overflow_d  = overflow_q  || (wr_en_i && full_q);
      underflow_d = underflow_q || (rd_en_i && empty_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_gen_sync_fifo.sv
// Scoreboard bench for gen_sync_fifo (DEPTH=8, AF_LEVEL=6); a negedge monitor
// compares every rd_valid_o word against the expected-read queue.
module tb_gen_sync_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en_i;
   logic [15:0] wr_data_i;
   logic        rd_en_i;
   logic [15:0] rd_data_o;
   logic        rd_valid_o;
   logic        full_o;
   logic        empty_o;
   logic        almost_full_o;
   logic [3:0]  count_o;
`ifdef GEN_FIFO_ERR_FLAGS_EN
   logic        overflow_o;
   logic        underflow_o;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] model_q[$];
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   gen_sync_fifo #(
      .DATA_WIDTH (16),
      .DEPTH      (8),
      .AF_LEVEL   (6)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_en_i       (wr_en_i),
      .wr_data_i     (wr_data_i),
      .rd_en_i       (rd_en_i),
      .rd_data_o     (rd_data_o),
      .rd_valid_o    (rd_valid_o),
      .full_o        (full_o),
      .empty_o       (empty_o),
      .almost_full_o (almost_full_o),
      .count_o       (count_o)
`ifdef GEN_FIFO_ERR_FLAGS_EN
      ,
      .overflow_o    (overflow_o),
      .underflow_o   (underflow_o)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every presented read word must match the oldest expected read.
   always @(negedge clk) begin
      if (!rst && rd_valid_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got %0h expected no read", rd_data_o);
         end else begin
            chk("rd_data", 32'(rd_data_o), 32'(exp_q.pop_front()));
         end
      end
   end

   // One clock of stimulus; the model tracks accepts on pre-edge occupancy.
   task automatic step(input logic w, input logic [15:0] d, input logic r);
      bit was_full;
      bit was_empty;
      wr_en_i   = w;
      wr_data_i = d;
      rd_en_i   = r;
      was_full  = (model_q.size() == 8);
      was_empty = (model_q.size() == 0);
      if (r && !was_empty) exp_q.push_back(model_q.pop_front());
      if (w && !was_full) model_q.push_back(d);
      @(posedge clk);
      #1;
      wr_en_i = 1'b0;
      rd_en_i = 1'b0;
      chk("count_model", 32'(count_o), 32'(model_q.size()));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      wr_en_i   = 1'b0;
      wr_data_i = 16'h0000;
      rd_en_i   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_empty", 32'(empty_o), 32'd1);
      chk("rst_full", 32'(full_o), 32'd0);
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_valid", 32'(rd_valid_o), 32'd0);
      chk("rst_data", 32'(rd_data_o), 32'h0000);
      chk("rst_af", 32'(almost_full_o), 32'd0);

      // Fill with 1..8, then drain in order
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 16'(i), 1'b0);
         chk("fill_count", 32'(count_o), 32'(i));
         chk("fill_af", 32'(almost_full_o), (i >= 6) ? 32'd1 : 32'd0);
         chk("fill_full", 32'(full_o), (i == 8) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 16'h0000, 1'b1);
         chk("drain_valid", 32'(rd_valid_o), 32'd1);
      end
      chk("drain_empty", 32'(empty_o), 32'd1);
      chk("drain_count", 32'(count_o), 32'd0);
      step(1'b0, 16'h0000, 1'b0);
      chk("idle_valid", 32'(rd_valid_o), 32'd0);

      // Full with simultaneous write and read: write dropped
      for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0);
      step(1'b1, 16'h7FFF, 1'b1);
      chk("full_rw_data", 32'(rd_data_o), 32'h0001);
      chk("full_rw_count", 32'(count_o), 32'd7);
      chk("full_rw_full", 32'(full_o), 32'd0);
`ifdef GEN_FIFO_ERR_FLAGS_EN
      chk("overflow_set", 32'(overflow_o), 32'd1);
`endif
      for (int i = 0; i < 7; i++) step(1'b0, 16'h0000, 1'b1);
      chk("full_rw_empty", 32'(empty_o), 32'd1);
`ifdef GEN_FIFO_ERR_FLAGS_EN
      chk("overflow_sticky", 32'(overflow_o), 32'd1);
`endif

      // Empty with simultaneous write and read: no fall-through
      step(1'b1, 16'hFF80, 1'b1);
      chk("empty_rw_valid", 32'(rd_valid_o), 32'd0);
      chk("empty_rw_count", 32'(count_o), 32'd1);
      step(1'b0, 16'h0000, 1'b1);
      chk("signed_data", 32'(rd_data_o), 32'h0000FF80);
      chk("signed_valid", 32'(rd_valid_o), 32'd1);
`ifdef GEN_FIFO_ERR_FLAGS_EN
      chk("underflow_set", 32'(underflow_o), 32'd1);
`endif

      // Streaming with 3 preloaded words
      for (int i = 0; i < 3; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 16'h0200 + 16'(i), 1'b1);
         chk("stream_count", 32'(count_o), 32'd3);
         chk("stream_valid", 32'(rd_valid_o), 32'd1);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1);
      chk("stream_empty", 32'(empty_o), 32'd1);

      // Reset with 5 words stored discards them
      for (int i = 0; i < 5; i++) step(1'b1, 16'h00A0 + 16'(i), 1'b0);
      chk("prerst_count", 32'(count_o), 32'd5);
      rst = 1'b1;
      model_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_count", 32'(count_o), 32'd0);
      chk("midrst_empty", 32'(empty_o), 32'd1);
      chk("midrst_valid", 32'(rd_valid_o), 32'd0);
`ifdef GEN_FIFO_ERR_FLAGS_EN
      chk("midrst_overflow", 32'(overflow_o), 32'd0);
`endif
      step(1'b0, 16'h0000, 1'b1);
      chk("postrst_rd_ignored", 32'(rd_valid_o), 32'd0);
      step(1'b1, 16'hBEEF, 1'b0);
      step(1'b0, 16'h0000, 1'b1);
      chk("postrst_data", 32'(rd_data_o), 32'h0000BEEF);
      step(1'b0, 16'h0000, 1'b0);
      @(negedge clk);
      chk("exp_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
